hc595_chain_driver: RTL and testbench
=====================================

# hc595_chain_driver

Parametrised serial driver for a chain of cascaded 74HC595 shift registers. It accepts a DATA_W-bit word through a ready/load handshake. It shifts the word out on ds/sh_cp at a programmable bit rate, in either bit order, then pulses st_cp to latch the chain outputs. It sits between display/LED control logic and the board-level sh_cp/st_cp/ds pins, which top drives today.

## Interface

- DATA_W, 16: total bits in the chain (8 × number of cascaded 595s); ≥1.
- CLK_DIV, 2: sys_clk cycles per sh_cp half-period and per st_cp pulse; ≥1.

- sys_clk  input  1  system clock (50 MHz on board).
- reset_n  input  1  reset, synchronous, active-low.
- data_in  input  DATA_W  word to transmit; sampled only on an accepted load.
- load  input  1  transfer request; accepted when load && ready at a sys_clk edge.
- lsb_first  input  1  bit order, sampled with data_in; 0 = MSB (bit DATA_W-1) first, 1 = LSB (bit 0) first.
- ready  output  1  high when idle and able to accept load.
- sh_cp  output  1  shift clock to the 595 chain.
- st_cp  output  1  storage/latch clock to the 595 chain.
- ds  output  1  serial data to the first 595.
- oe_n  output  1  output enable, active-low; present only with HC595_OE_EN.

## Operation

- FSM states: IDLE, SHIFT, LATCH. All outputs are registered.
- Reset (reset_n low at an edge):
  - Next cycle: state IDLE, ready=1, sh_cp=0, st_cp=0, ds=0, all counters 0.
  - oe_n=1.
- IDLE:
  - ready=1; sh_cp, st_cp and ds held 0.
  - When load && ready: capture data_in and lsb_first into the shift register and go to SHIFT.
  - On the cycle after acceptance, ready=0.
- SHIFT:
  - The word goes out as DATA_W bit slots of 2×CLK_DIV cycles each.
  - In each slot, ds presents the current bit from the slot's first cycle.
  - sh_cp is 0 for the first CLK_DIV cycles of the slot and 1 for the last CLK_DIV cycles.
  - ds changes only at slot start, while sh_cp is low, so data is stable across the sh_cp rising edge.
  - The shift register moves one position per slot, left for MSB-first and right for LSB-first.
- LATCH:
  - After the last slot: sh_cp=0, ds=0, st_cp=1 for CLK_DIV cycles.
  - Then go to IDLE with ready=1.
- Bit counter width is $clog2(DATA_W+1). Divider counter width is $clog2(2×CLK_DIV). Neither counter may wrap before its terminal count.
- Boundary conditions:
  - load while ready=0: ignored and not queued. The in-flight word completes unchanged.
  - data_in/lsb_first changing mid-transfer: no effect.
  - load held high continuously: a new word is accepted on the first IDLE cycle. Transfers are separated by exactly one IDLE cycle.
  - Reset mid-SHIFT or mid-LATCH: the transfer is abandoned. No further sh_cp edges and no st_cp pulse is issued after reset; if st_cp is already high it drops with reset.
  - DATA_W=1 and CLK_DIV=1 must work (slot = 2 cycles, latch pulse = 1 cycle).

## Timing

- Acceptance edge = cycle 0. SHIFT occupies cycles 1 to DATA_W×2×CLK_DIV.
- First bit on ds at cycle 1. First sh_cp rising edge at cycle 1+CLK_DIV.
- st_cp is high for cycles DATA_W×2×CLK_DIV+1 to DATA_W×2×CLK_DIV+CLK_DIV.
- ready is low for exactly DATA_W×2×CLK_DIV + CLK_DIV cycles.
- Exactly DATA_W sh_cp rising edges and one st_cp pulse per accepted load.
- st_cp never overlaps sh_cp high.

## Configuration

- HC595_OE_EN defined:
  - Adds the oe_n port.
  - oe_n=1 from reset until the falling edge of the first st_cp pulse after reset; 0 from the following cycle onward.
  - This prevents power-up garbage on the 595 outputs.
- HC595_OE_EN undefined: the oe_n port and its logic are absent. The board ties 595 OE low.

## Test plan

- MSB-first transfer (DATA_W=16, CLK_DIV=2): load 16'hA5C3, lsb_first=0.
  - ds sampled on 16 sh_cp rises = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1.
  - One st_cp pulse 2 cycles wide; ready low 66 cycles.
- LSB-first transfer: load 16'hA5C3, lsb_first=1 → ds = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
- Load while busy: pulse load with 16'hFFFF at cycle 10 of a 16'h0001 MSB-first transfer.
  - Exactly 16 sh_cp rises; only the final bit is 1.
  - ready does not drop early or extend.
- Load held high: two words back-to-back, with exactly one ready=1 IDLE cycle between the st_cp fall and the next ds bit.
- Reset mid-transfer: reset_n low for 1 cycle after 5 sh_cp rises.
  - Next cycle: sh_cp=st_cp=ds=0, ready=1.
  - No st_cp pulse until a new load is accepted.
- With HC595_OE_EN, DATA_W=8, CLK_DIV=1:
  - oe_n=1 after reset through the first st_cp pulse, then 0.
  - A second reset returns oe_n to 1.

Source files
------------

// File: rtl/hc595_chain_driver.sv
// hc595_chain_driver: serial driver for a cascaded chain of 74HC595 shift registers.
//
// A DATA_W-bit word is accepted on load && ready. It is shifted out on ds/sh_cp
// as DATA_W bit slots of 2*CLK_DIV cycles each: sh_cp is low for the first half
// of a slot and high for the second half. st_cp is then pulsed for CLK_DIV cycles.
// All outputs are registered.
//
// Optional feature macro: HC595_OE_EN adds oe_n. oe_n is held high from reset
// until the first st_cp pulse has fallen.
//
// Ports:
//   sys_clk    system clock
//   reset_n    synchronous active-low reset
//   data_in    word to transmit, captured on an accepted load
//   load       transfer request
//   lsb_first  bit order captured with data_in (0 = MSB first, 1 = LSB first)
//   ready      idle and able to accept load
//   sh_cp      shift clock to the chain
//   st_cp      storage/latch clock to the chain
//   ds         serial data to the first 595
//   oe_n       active-low output enable (HC595_OE_EN only)
module hc595_chain_driver #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  input  logic              lsb_first,
  output logic              ready,
  output logic              sh_cp,
  output logic              st_cp,
`ifdef HC595_OE_EN
  output logic              oe_n,
`endif
  output logic              ds
);

  localparam int unsigned BIT_W = $clog2(DATA_W + 1);
  localparam int unsigned DIV_W = $clog2(2 * CLK_DIV);

  localparam logic [DIV_W-1:0] SLOT_LAST  = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] HALF       = DIV_W'(CLK_DIV);
  localparam logic [DIV_W-1:0] LATCH_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_t;

  state_t              state, state_n;
  logic [DATA_W-1:0]   shreg, shreg_n, shifted;
  logic                dir, dir_n;
  logic [DIV_W-1:0]    div_cnt, div_n, div_inc;
  logic [BIT_W-1:0]    bit_cnt, bit_n;
  logic                ready_n, sh_n, st_n, ds_n;
`ifdef HC595_OE_EN
  logic                oe_n_n;
`endif

  // State and registered outputs
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      shreg   <= '0;
      dir     <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      ready   <= 1'b1;
      sh_cp   <= 1'b0;
      st_cp   <= 1'b0;
      ds      <= 1'b0;
`ifdef HC595_OE_EN
      oe_n    <= 1'b1;
`endif
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      dir     <= dir_n;
      div_cnt <= div_n;
      bit_cnt <= bit_n;
      ready   <= ready_n;
      sh_cp   <= sh_n;
      st_cp   <= st_n;
      ds      <= ds_n;
`ifdef HC595_OE_EN
      oe_n    <= oe_n_n;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    dir_n   = dir;
    div_n   = div_cnt;
    bit_n   = bit_cnt;
    ready_n = ready;
    sh_n    = sh_cp;
    st_n    = st_cp;
    ds_n    = ds;
    shifted = dir ? (shreg >> 1) : (shreg << 1);
    div_inc = div_cnt + DIV_W'(1);

    case (state)
      IDLE: begin
        ready_n = 1'b1;
        sh_n    = 1'b0;
        st_n    = 1'b0;
        ds_n    = 1'b0;
        div_n   = '0;
        bit_n   = '0;
        if (load && ready) begin
          state_n = SHIFT;
          shreg_n = data_in;
          dir_n   = lsb_first;
          ds_n    = lsb_first ? data_in[0] : data_in[DATA_W-1];
          ready_n = 1'b0;
        end
      end

      SHIFT: begin
        if (div_cnt == SLOT_LAST) begin
          // Slot boundary: present the next bit while sh_cp returns low.
          div_n = '0;
          sh_n  = 1'b0;
          if (bit_cnt == BIT_LAST) begin
            state_n = LATCH;
            bit_n   = '0;
            ds_n    = 1'b0;
            st_n    = 1'b1;
          end else begin
            bit_n   = bit_cnt + BIT_W'(1);
            shreg_n = shifted;
            ds_n    = dir ? shifted[0] : shifted[DATA_W-1];
          end
        end else begin
          div_n = div_inc;
          sh_n  = (div_inc >= HALF);
        end
      end

      LATCH: begin
        if (div_cnt == LATCH_LAST) begin
          state_n = IDLE;
          div_n   = '0;
          st_n    = 1'b0;
          ready_n = 1'b1;
        end else begin
          div_n = div_inc;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

`ifdef HC595_OE_EN
  // Release output enable once the first latch pulse has completed.
  always_comb begin
    oe_n_n = oe_n;
    if (st_cp && !st_n) begin
      oe_n_n = 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_hc595_chain_driver.sv
// Self-checking bench for hc595_chain_driver (DATA_W=16, CLK_DIV=2).
module tb_hc595_chain_driver;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned CLK_DIV  = 2;
  localparam int          SLOT     = 2 * CLK_DIV;
  localparam int          XFER_LOW = DATA_W * SLOT + CLK_DIV;

  logic              sys_clk = 1'b0;
  logic              reset_n;
  logic [DATA_W-1:0] data_in;
  logic              load;
  logic              lsb_first;
  logic              ready;
  logic              sh_cp;
  logic              st_cp;
  logic              ds;
`ifdef HC595_OE_EN
  logic              oe_n;
`endif

  always #5 sys_clk = ~sys_clk;

  hc595_chain_driver #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
    .sys_clk   (sys_clk),
    .reset_n   (reset_n),
    .data_in   (data_in),
    .load      (load),
    .lsb_first (lsb_first),
    .ready     (ready),
    .sh_cp     (sh_cp),
    .st_cp     (st_cp),
`ifdef HC595_OE_EN
    .oe_n      (oe_n),
`endif
    .ds        (ds)
  );

  // Pin monitor: records what a 595 chain would see.
  int   cyc = 0;
  logic prev_sh = 1'b0, prev_st = 1'b0, prev_ds = 1'b0;
  bit   rise_bits[$];
  int   rise_cyc[$];
  int   st_rise_cyc[$];
  int   st_hi = 0, st_pulses = 0, ready_low = 0, overlap = 0, glitch = 0;

  always @(negedge sys_clk) begin
    cyc <= cyc + 1;
    if (sh_cp && !prev_sh) begin
      rise_bits.push_back(ds);
      rise_cyc.push_back(cyc + 1);
    end
    if (sh_cp && prev_sh && (ds != prev_ds)) glitch <= glitch + 1;
    if (st_cp) st_hi <= st_hi + 1;
    if (st_cp && !prev_st) begin
      st_pulses <= st_pulses + 1;
      st_rise_cyc.push_back(cyc + 1);
    end
    if (!ready) ready_low <= ready_low + 1;
    if (st_cp && sh_cp) overlap <= overlap + 1;
    prev_sh <= sh_cp;
    prev_st <= st_cp;
    prev_ds <= ds;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 4 * XFER_LOW; i++) begin
      if (ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check({name, " ready timeout"}, 0, 1);
  endtask

  // Reference: order in which the chain receives the word, first bit in [15].
  function automatic logic [15:0] model_seq(input logic [15:0] w, input logic lsb);
    logic [15:0] s;
    for (int i = 0; i < DATA_W; i++) s[15-i] = lsb ? w[i] : w[15-i];
    return s;
  endfunction

  function automatic logic [15:0] bits_from(input int start);
    logic [15:0] g = '0;
    for (int i = 0; i < DATA_W; i++)
      if (start + i < rise_bits.size()) g[15-i] = rise_bits[start+i];
    return g;
  endfunction

  // One full transfer with optional load pulse at cycle busy_at while busy.
  task automatic xfer(input string name, input logic [15:0] word, input logic lsb,
                      input logic [15:0] exp, input int busy_at);
    int r0, sc0, sp0, sh0, rl0, ov0, gl0, t0;
    bit done = 1'b0;
    wait_ready(name);
    r0 = rise_bits.size(); sc0 = st_rise_cyc.size();
    sp0 = st_pulses; sh0 = st_hi; rl0 = ready_low; ov0 = overlap; gl0 = glitch;
    data_in = word; lsb_first = lsb; load = 1'b1; t0 = cyc;
    tick();
    load = 1'b0; data_in = ~word; lsb_first = ~lsb;
    if (busy_at > 0) begin
      for (int c = 1; c < busy_at; c++) tick();
      load = 1'b1; data_in = 16'hFFFF;
      tick();
      load = 1'b0;
    end
    for (int i = 0; i < 2 * XFER_LOW; i++) begin
      if (ready) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check({name, " completion"}, int'(done), 1);
    check({name, " rises"}, rise_bits.size() - r0, DATA_W);
    check({name, " bits"}, int'(bits_from(r0)), int'(exp));
    check({name, " first rise cycle"},
          (rise_bits.size() > r0) ? rise_cyc[r0] - t0 : -1, 1 + CLK_DIV);
    check({name, " st pulses"}, st_pulses - sp0, 1);
    check({name, " st width"}, st_hi - sh0, CLK_DIV);
    check({name, " st start cycle"},
          (st_rise_cyc.size() > sc0) ? st_rise_cyc[sc0] - t0 : -1, DATA_W * SLOT + 1);
    check({name, " ready low"}, ready_low - rl0, XFER_LOW);
    check({name, " overlap"}, overlap - ov0, 0);
    check({name, " ds glitch"}, glitch - gl0, 0);
  endtask

  typedef struct {
    logic [15:0] word;
    logic        lsb;
    logic [15:0] seq;
    int          busy;
  } vec_t;

  vec_t vt[7];

  initial begin
    int r0, sp0, tr;
    logic [15:0] w;
    logic        l;

    vt[0] = '{16'hA5C3, 1'b0, 16'hA5C3, 0};
    vt[1] = '{16'hA5C3, 1'b1, 16'hC3A5, 0};
    vt[2] = '{16'h0001, 1'b0, 16'h0001, 10};
    vt[3] = '{16'h8000, 1'b1, 16'h0001, 0};
    vt[4] = '{16'hFFFF, 1'b0, 16'hFFFF, 0};
    vt[5] = '{16'h0000, 1'b1, 16'h0000, 20};
    vt[6] = '{16'h1357, 1'b1, 16'hEAC8, 0};

    reset_n = 1'b0; load = 1'b0; data_in = '0; lsb_first = 1'b0;
    repeat (3) tick();
    check("reset ready", ready, 1);
    check("reset sh_cp", sh_cp, 0);
    check("reset st_cp", st_cp, 0);
    check("reset ds", ds, 0);
`ifdef HC595_OE_EN
    check("reset oe_n", oe_n, 1);
`endif
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++)
      xfer($sformatf("vec%0d", i), vt[i].word, vt[i].lsb, vt[i].seq, vt[i].busy);
`ifdef HC595_OE_EN
    check("oe_n after latch", oe_n, 0);
`endif

    // Load held high: back-to-back words with one idle cycle between.
    wait_ready("hold");
    r0 = rise_bits.size();
    data_in = 16'h1234; lsb_first = 1'b0; load = 1'b1;
    tick();
    data_in = 16'hBEEF;
    tr = -1;
    for (int i = 0; i < 2 * XFER_LOW; i++) begin
      if (ready) begin
        tr = cyc;
        break;
      end
      tick();
    end
    check("hold first done", int'(tr >= 0), 1);
    check("hold idle st_cp", st_cp, 0);
    tick();
    check("hold single idle", ready, 0);
    check("hold second first bit", ds, 1);
    load = 1'b0;
    wait_ready("hold2");
    check("hold rises", rise_bits.size() - r0, 2 * DATA_W);
    check("hold bits word1", int'(bits_from(r0)), 16'h1234);
    check("hold bits word2", int'(bits_from(r0 + DATA_W)), 16'hBEEF);
    check("hold word2 first rise",
          (rise_bits.size() > r0 + DATA_W) ? rise_cyc[r0+DATA_W] - tr : -1, 1 + CLK_DIV);

    // Reset mid-transfer after 5 rises.
    wait_ready("rst");
    r0 = rise_bits.size();
    data_in = 16'hFFFF; lsb_first = 1'b0; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 2 * XFER_LOW; i++) begin
      if (rise_bits.size() - r0 >= 5) break;
      tick();
    end
    check("rst rises before", rise_bits.size() - r0, 5);
    reset_n = 1'b0;
    tick();
    check("rst sh_cp", sh_cp, 0);
    check("rst st_cp", st_cp, 0);
    check("rst ds", ds, 0);
    check("rst ready", ready, 1);
`ifdef HC595_OE_EN
    check("rst oe_n", oe_n, 1);
`endif
    reset_n = 1'b1;
    r0 = rise_bits.size(); sp0 = st_pulses;
    repeat (80) tick();
    check("rst no rises", rise_bits.size() - r0, 0);
    check("rst no st pulse", st_pulses - sp0, 0);
    check("rst idle ready", ready, 1);

    // Randomized transfers against the bit-order model.
    for (int i = 0; i < 10; i++) begin
      w = 16'($urandom);
      l = 1'($urandom);
      xfer($sformatf("rand%0d", i), w, l, model_seq(w, l),
           ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 60)) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
